hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Decode-stage hazard detector and the counterpart to the EX-stage forwarding unit. It tracks registers whose results are still owed by long-latency ops (multi-cycle mul/div, cache-miss loads), which forwarding cannot cover. It stalls IFID on RAW, WAW, load-use or structural (too many outstanding ops) hazards, and releases each register when its writeback retires.

Parameters:
NUM_REGS, 32, architectural registers; index 0 is hard-wired zero.
MAX_OUTSTANDING, 4, maximum simultaneously pending long ops.
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_IFID_rs1  in  5  decode-stage source 1
in_IFID_rs2  in  5  decode-stage source 2
in_IFID_uses_rs1  in  1  decode instruction reads rs1
in_IFID_uses_rs2  in  1  decode instruction reads rs2
in_IFID_rd  in  5  decode-stage destination
in_IFID_write_enable  in  1  decode instruction writes rd
in_IFID_is_long  in  1  decode instruction is a long-latency op
in_IDEX_rd  in  5  EX-stage destination
in_IDEX_write_enable  in  1  EX instruction writes rd
in_IDEX_mem_read  in  1  EX instruction is a load
in_IDEX_is_long  in  1  EX instruction is a long op; issues this cycle
in_flush  in  1  squash of IFID/IDEX from a branch redirect
in_WB_long_valid  in  1  a long op retires this cycle
in_WB_long_rd  in  5  register being retired
out_stall  out  1  hold PC/IFID, insert bubble into IDEX
out_pending  out  NUM_REGS  registered pending bit vector
out_outstanding  out  CNT_W  count of pending long ops
out_error  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high) clears out_pending, out_outstanding and out_error. out_stall is then 0 unless the current inputs alone cause a load-use hazard.
- out_pending[0] is always 0. Writes to x0 are never tracked.
- Issue accept condition: in_IDEX_is_long & in_IDEX_write_enable & in_IDEX_rd!=0 & !in_flush. On the next edge, pending[rd] is set and the outstanding count is incremented.
- Retire: when in_WB_long_valid and pending[in_WB_long_rd] are both set, that bit is cleared and the count is decremented on the next edge.
- Issue and retire in the same cycle:
  - Different registers: both take effect and the count is unchanged.
  - Same register: set wins.
- Retire to a non-pending register, or to x0: ignored, and out_error sets sticky until reset.
- An accept while the count equals MAX_OUTSTANDING cannot occur, because the structural stall prevents it. If it does occur, it is dropped and out_error sets.
- out_stall is combinational from registered state plus the current inputs. A source hazard exists on rsN (N=1,2) when in_IFID_uses_rsN & rsN!=0 and either:
  - (a) RAW-pending: out_pending[rsN];
  - (b) load-use or long-in-EX: (in_IDEX_mem_read | in_IDEX_is_long) & in_IDEX_write_enable & in_IDEX_rd==rsN.
- Other hazards:
  - (c) WAW: in_IFID_write_enable & in_IFID_rd!=0 & (out_pending[rd] | (in_IDEX_is_long & in_IDEX_rd==rd)).
  - (d) Structural: in_IFID_is_long & the projected count (current count + accept − retire) == MAX_OUTSTANDING.
- out_stall = (a|b|c|d) & !in_flush. A flush squashes the decode instruction, so it never stalls.
- No same-cycle bypass from retire: the pending bit clears at the edge, so the stall drops one cycle after in_WB_long_valid. Decided; costs one cycle.
- in_flush never clears pending bits. Issued long ops are older than the redirect and must still retire.
- Latency: register state is visible on out_pending one cycle after the accept or retire.

Optional Feature:
SCOREBOARD_STATS_EN
- Defined: adds out_stall_cycles[31:0] and out_struct_stall_cycles[31:0]. These are saturating counters of cycles with out_stall, and with stall caused only by (d). Both clear on reset.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package pipeline_pkg:
  - REG_IDX_W = 5
  - NUM_ARCH_REGS = 32
  - typedef reg_idx_t
  - a stall_cause_t enum (NONE, RAW, LOADUSE, WAW, STRUCT) for debug visibility
- One natural sub-module, hazard_match: per-source combinational comparator returning a stall_cause_t. It is instantiated twice, for rs1 and rs2.

Test Plan:
- Load-use: IDEX lw x5 (mem_read=1, rd=5); IFID add uses rs1=5 -> out_stall=1 for that cycle. Next cycle, with IDEX bubbled -> out_stall=0.
- Long RAW: issue mul x7 -> out_pending[7]=1 next cycle and out_outstanding=1. IFID rs2=7 -> stall held until WB retires rd=7, then drops one cycle later with the count back to 0.
- WAW: x9 pending; IFID is a long op with write_enable=1 and rd=9 -> out_stall=1 until x9 retires.
- Structural: issue 4 long ops to x1..x4 -> count=4. A 5th long op in IFID -> stall. Retire x2 -> the stall clears in the same cycle via the projected count.
- Simultaneous: issue x3 and retire x3 in one cycle -> pending[3]=1 and the count is unchanged. Retire x12 when not pending -> out_error=1, held until reset.
- Flush and reset: in_flush with an IDEX long op -> no pending bit set and out_stall=0. Reset asserted mid-operation with 3 pending -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_pkg                                                             |
// | Shared pipeline types: register index and hazard stall-cause encoding.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipeline_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_RAW     = 3'd1,
    CAUSE_LOADUSE = 3'd2,
    CAUSE_WAW     = 3'd3,
    CAUSE_STRUCT  = 3'd4
  } stall_cause_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_scoreboard_if                                                     |
// | Decode/EX/WB hazard bus between the pipeline and the hazard scoreboard.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface hazard_scoreboard_if
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int CNT_W    = 3
);

  reg_idx_t            in_IFID_rs1;
  reg_idx_t            in_IFID_rs2;
  logic                in_IFID_uses_rs1;
  logic                in_IFID_uses_rs2;
  reg_idx_t            in_IFID_rd;
  logic                in_IFID_write_enable;
  logic                in_IFID_is_long;
  reg_idx_t            in_IDEX_rd;
  logic                in_IDEX_write_enable;
  logic                in_IDEX_mem_read;
  logic                in_IDEX_is_long;
  logic                in_flush;
  logic                in_WB_long_valid;
  reg_idx_t            in_WB_long_rd;
  logic                out_stall;
  logic [NUM_REGS-1:0] out_pending;
  logic [CNT_W-1:0]    out_outstanding;
  logic                out_error;

  modport master (
    output in_IFID_rs1, in_IFID_rs2, in_IFID_uses_rs1, in_IFID_uses_rs2,
           in_IFID_rd, in_IFID_write_enable, in_IFID_is_long,
           in_IDEX_rd, in_IDEX_write_enable, in_IDEX_mem_read, in_IDEX_is_long,
           in_flush, in_WB_long_valid, in_WB_long_rd,
    input  out_stall, out_pending, out_outstanding, out_error
  );

  modport slave (
    input  in_IFID_rs1, in_IFID_rs2, in_IFID_uses_rs1, in_IFID_uses_rs2,
           in_IFID_rd, in_IFID_write_enable, in_IFID_is_long,
           in_IDEX_rd, in_IDEX_write_enable, in_IDEX_mem_read, in_IDEX_is_long,
           in_flush, in_WB_long_valid, in_WB_long_rd,
    output out_stall, out_pending, out_outstanding, out_error
  );

endinterface
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_match                                                             |
// | Per-source comparator: RAW against pending regs, load-use/long-in-EX.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS
) (
  input  logic                uses_rs,
  input  reg_idx_t            rs,
  input  logic [NUM_REGS-1:0] pending,
  input  reg_idx_t            idex_rd,
  input  logic                idex_write_enable,
  input  logic                idex_mem_read,
  input  logic                idex_is_long,
  output stall_cause_t        cause
);

  always_comb begin
    cause = CAUSE_NONE;
    if (uses_rs && (rs != '0)) begin
      if (pending[rs]) begin
        cause = CAUSE_RAW;
      end else if ((idex_mem_read || idex_is_long) && idex_write_enable &&
                   (idex_rd == rs)) begin
        cause = CAUSE_LOADUSE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_scoreboard                                                        |
// | Decode-stage scoreboard for long-latency results; stalls IFID on RAW,    |
// | load-use, WAW and structural hazards. Optional stall counters are        |
// | enabled with macro SCOREBOARD_STATS_EN.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS        = NUM_ARCH_REGS,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0]        out_stall_cycles,
  output logic [31:0]        out_struct_stall_cycles,
`endif
  hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                error_q, error_d;

  logic         accept_req, accept, full, retire;
  logic         src_hazard, waw_hazard, struct_hazard, stall;
  stall_cause_t rs1_cause, rs2_cause;

  hazard_match #(.NUM_REGS(NUM_REGS)) u_match_rs1 (
    .uses_rs           (bus.in_IFID_uses_rs1),
    .rs                (bus.in_IFID_rs1),
    .pending           (pending_q),
    .idex_rd           (bus.in_IDEX_rd),
    .idex_write_enable (bus.in_IDEX_write_enable),
    .idex_mem_read     (bus.in_IDEX_mem_read),
    .idex_is_long      (bus.in_IDEX_is_long),
    .cause             (rs1_cause)
  );

  hazard_match #(.NUM_REGS(NUM_REGS)) u_match_rs2 (
    .uses_rs           (bus.in_IFID_uses_rs2),
    .rs                (bus.in_IFID_rs2),
    .pending           (pending_q),
    .idex_rd           (bus.in_IDEX_rd),
    .idex_write_enable (bus.in_IDEX_write_enable),
    .idex_mem_read     (bus.in_IDEX_mem_read),
    .idex_is_long      (bus.in_IDEX_is_long),
    .cause             (rs2_cause)
  );

  always_comb begin
    accept_req = bus.in_IDEX_is_long && bus.in_IDEX_write_enable &&
                 (bus.in_IDEX_rd != '0) && !bus.in_flush;
    full       = (outstanding_q == MAX_CNT);
    accept     = accept_req && !full;
    // x0 is never pending, so a retire to x0 falls out as an error too.
    retire     = bus.in_WB_long_valid && pending_q[bus.in_WB_long_rd];

    pending_d = pending_q;
    if (retire) pending_d[bus.in_WB_long_rd] = 1'b0;
    if (accept) pending_d[bus.in_IDEX_rd]    = 1'b1;
    pending_d[0] = 1'b0;

    outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, accept}
                                  - {{(CNT_W-1){1'b0}}, retire};

    error_d = error_q || (bus.in_WB_long_valid && !retire) || (accept_req && full);
  end

  always_comb begin
    src_hazard    = (rs1_cause != CAUSE_NONE) || (rs2_cause != CAUSE_NONE);
    waw_hazard    = bus.in_IFID_write_enable && (bus.in_IFID_rd != '0) &&
                    (pending_q[bus.in_IFID_rd] ||
                     (bus.in_IDEX_is_long && (bus.in_IDEX_rd == bus.in_IFID_rd)));
    // Projected count lets a same-cycle retire release the structural stall.
    struct_hazard = bus.in_IFID_is_long && (outstanding_d == MAX_CNT);
    stall         = (src_hazard || waw_hazard || struct_hazard) && !bus.in_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  assign bus.out_stall       = stall;
  assign bus.out_pending     = pending_q;
  assign bus.out_outstanding = outstanding_q;
  assign bus.out_error       = error_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] struct_cycles_q, struct_cycles_d;
  logic        struct_only;

  always_comb begin
    struct_only     = stall && struct_hazard && !src_hazard && !waw_hazard;
    stall_cycles_d  = stall_cycles_q;
    struct_cycles_d = struct_cycles_q;
    if (stall && (stall_cycles_q != '1))        stall_cycles_d  = stall_cycles_q + 32'd1;
    if (struct_only && (struct_cycles_q != '1)) struct_cycles_d = struct_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q  <= '0;
      struct_cycles_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      struct_cycles_q <= struct_cycles_d;
    end
  end

  assign out_stall_cycles        = stall_cycles_q;
  assign out_struct_stall_cycles = struct_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_scoreboard                                                     |
// | Directed self-checking bench for hazard_scoreboard.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_scoreboard;
  import pipeline_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.NUM_REGS(32), .CNT_W(3)) bus ();

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] struct_stall_cycles;
`endif

  hazard_scoreboard #(.NUM_REGS(32), .MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk                     (clk),
    .reset                   (reset),
`ifdef SCOREBOARD_STATS_EN
    .out_stall_cycles        (stall_cycles),
    .out_struct_stall_cycles (struct_stall_cycles),
`endif
    .bus                     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.in_IFID_rs1          = '0;
    bus.in_IFID_rs2          = '0;
    bus.in_IFID_uses_rs1     = 1'b0;
    bus.in_IFID_uses_rs2     = 1'b0;
    bus.in_IFID_rd           = '0;
    bus.in_IFID_write_enable = 1'b0;
    bus.in_IFID_is_long      = 1'b0;
    bus.in_IDEX_rd           = '0;
    bus.in_IDEX_write_enable = 1'b0;
    bus.in_IDEX_mem_read     = 1'b0;
    bus.in_IDEX_is_long      = 1'b0;
    bus.in_flush             = 1'b0;
    bus.in_WB_long_valid     = 1'b0;
    bus.in_WB_long_rd        = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.in_IDEX_is_long      = 1'b1;
    bus.in_IDEX_write_enable = 1'b1;
    bus.in_IDEX_rd           = rd;
  endtask

  task automatic retire(input logic [4:0] rd);
    bus.in_WB_long_valid = 1'b1;
    bus.in_WB_long_rd    = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_pending", bus.out_pending, 32'h0);
    check("rst_count", 32'(bus.out_outstanding), 32'd0);
    check("rst_error", 32'(bus.out_error), 32'd0);
    check("rst_stall", 32'(bus.out_stall), 32'd0);

    // load-use
    step();
    bus.in_IDEX_rd = 5'd5; bus.in_IDEX_write_enable = 1'b1; bus.in_IDEX_mem_read = 1'b1;
    bus.in_IFID_uses_rs1 = 1'b1; bus.in_IFID_rs1 = 5'd5;
    @(negedge clk);
    check("lu_stall", 32'(bus.out_stall), 32'd1);
    step();
    bus.in_IDEX_rd = '0; bus.in_IDEX_write_enable = 1'b0; bus.in_IDEX_mem_read = 1'b0;
    @(negedge clk);
    check("lu_bubble_stall", 32'(bus.out_stall), 32'd0);
    check("lu_pending", bus.out_pending, 32'h0);

    // long RAW on x7
    step();
    idle(); issue(5'd7);
    bus.in_IFID_uses_rs2 = 1'b1; bus.in_IFID_rs2 = 5'd7;
    @(negedge clk);
    check("raw_ex_stall", 32'(bus.out_stall), 32'd1);
    step();
    bus.in_IDEX_is_long = 1'b0; bus.in_IDEX_write_enable = 1'b0; bus.in_IDEX_rd = '0;
    @(negedge clk);
    check("raw_pending", bus.out_pending, 32'h80);
    check("raw_count", 32'(bus.out_outstanding), 32'd1);
    check("raw_stall", 32'(bus.out_stall), 32'd1);
    step();
    retire(5'd7);
    @(negedge clk);
    check("raw_retire_stall", 32'(bus.out_stall), 32'd1);
    step();
    bus.in_WB_long_valid = 1'b0;
    @(negedge clk);
    check("raw_release_stall", 32'(bus.out_stall), 32'd0);
    check("raw_release_count", 32'(bus.out_outstanding), 32'd0);
    check("raw_release_pending", bus.out_pending, 32'h0);

    // WAW on x9
    step();
    idle(); issue(5'd9);
    step();
    idle();
    bus.in_IFID_write_enable = 1'b1; bus.in_IFID_rd = 5'd9; bus.in_IFID_is_long = 1'b1;
    @(negedge clk);
    check("waw_pending", bus.out_pending, 32'h200);
    check("waw_stall", 32'(bus.out_stall), 32'd1);
    step();
    retire(5'd9);
    @(negedge clk);
    check("waw_retire_stall", 32'(bus.out_stall), 32'd1);
    step();
    bus.in_WB_long_valid = 1'b0;
    @(negedge clk);
    check("waw_release_stall", 32'(bus.out_stall), 32'd0);

    // structural: x1..x4 outstanding
    for (int i = 1; i <= 4; i++) begin
      step();
      idle(); issue(5'(i));
    end
    step();
    idle();
    bus.in_IFID_is_long = 1'b1; bus.in_IFID_write_enable = 1'b1; bus.in_IFID_rd = 5'd10;
    @(negedge clk);
    check("st_count", 32'(bus.out_outstanding), 32'd4);
    check("st_pending", bus.out_pending, 32'h1E);
    check("st_stall", 32'(bus.out_stall), 32'd1);
    step();
    retire(5'd2);
    @(negedge clk);
    check("st_retire_stall", 32'(bus.out_stall), 32'd0);
    step();
    idle();
    @(negedge clk);
    check("st_after_count", 32'(bus.out_outstanding), 32'd3);
    check("st_after_pending", bus.out_pending, 32'h1A);

    // simultaneous issue and retire of x3
    step();
    issue(5'd3); retire(5'd3);
    step();
    idle();
    @(negedge clk);
    check("sim_pending", bus.out_pending, 32'h1A);
    check("sim_count", 32'(bus.out_outstanding), 32'd3);
    check("sim_error", 32'(bus.out_error), 32'd0);

    // fill to 4, then an illegal accept while full is dropped
    step();
    issue(5'd5);
    step();
    idle(); issue(5'd6);
    @(negedge clk);
    check("full_pending", bus.out_pending, 32'h3A);
    check("full_count", 32'(bus.out_outstanding), 32'd4);
    step();
    idle();
    @(negedge clk);
    check("drop_pending", bus.out_pending, 32'h3A);
    check("drop_count", 32'(bus.out_outstanding), 32'd4);
    check("drop_error", 32'(bus.out_error), 32'd1);

    // flush: no stall, long op in EX is not tracked
    step();
    issue(5'd8); bus.in_flush = 1'b1;
    bus.in_IFID_uses_rs1 = 1'b1; bus.in_IFID_rs1 = 5'd1;
    bus.in_IFID_uses_rs2 = 1'b1; bus.in_IFID_rs2 = 5'd8;
    @(negedge clk);
    check("flush_stall", 32'(bus.out_stall), 32'd0);
    step();
    idle();
    @(negedge clk);
    check("flush_pending", bus.out_pending, 32'h3A);

    // retire x5 down to 3 pending, then reset
    step();
    retire(5'd5);
    step();
    idle();
    @(negedge clk);
    check("pre_rst_count", 32'(bus.out_outstanding), 32'd3);
    check("pre_rst_pending", bus.out_pending, 32'h1A);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pending", bus.out_pending, 32'h0);
    check("mid_rst_count", 32'(bus.out_outstanding), 32'd0);
    check("mid_rst_error", 32'(bus.out_error), 32'd0);

    // retire of a non-pending register is a sticky error
    step();
    retire(5'd12);
    step();
    idle();
    @(negedge clk);
    check("bad_ret_error", 32'(bus.out_error), 32'd1);
    check("bad_ret_count", 32'(bus.out_outstanding), 32'd0);
    step();
    @(negedge clk);
    check("bad_ret_sticky", 32'(bus.out_error), 32'd1);

    // retire to x0 is also an error
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    retire(5'd0);
    step();
    idle();
    @(negedge clk);
    check("x0_ret_error", 32'(bus.out_error), 32'd1);
    check("x0_pending", bus.out_pending, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
